// File: rtl/uart_pkt_pkg.sv
// uart_pkt_pkg: FIFO entry layout and FSM state encoding shared by the UART packetizer.
package uart_pkt_pkg;
  localparam int ENTRY_W = 10;
  typedef struct packed {
    logic       err;
    logic       last;
    logic [7:0] data;
  } entry_t;
  typedef enum logic { ST_IDLE, ST_HOLD } state_t;
endpackage

// File: rtl/uart_pkt_fifo.sv
// uart_pkt_fifo: synchronous first-word fall-through FIFO; a write to a full FIFO succeeds when a read happens in the same cycle.
module uart_pkt_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr,
  input  logic [W-1:0] wr_data,
  input  logic         rd,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp, rp;
  logic         wr_ok, rd_ok;
  assign empty   = wp == rp;
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign rd_ok   = rd & ~empty;
  assign wr_ok   = wr & (~full | rd_ok);
  assign rd_data = mem[rp[AW-1:0]];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr_ok) wp <= wp + 1'b1;
      if (rd_ok) rp <= rp + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (wr_ok) mem[wp[AW-1:0]] <= wr_data;
endmodule

// File: rtl/uart_rx_packetizer.sv
// uart_rx_packetizer: groups UART bytes into AXI-Stream packets closed by an idle gap or max length.
// Define UART_PKT_STATS_EN to enable the pkt_cnt/drop_cnt statistics counters.
module uart_rx_packetizer
  import uart_pkt_pkg::*;
#(
  parameter int IDLE_CYCLES = 1000,
  parameter int MAX_PKT_LEN = 64,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_err,
  input  logic [4:0]  tdest,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tkeep,
  output logic [4:0]  m_axis_tdest,
  output logic        m_axis_tuser,
  output logic [15:0] pkt_cnt,
  output logic [15:0] drop_cnt
);
  localparam int IW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  state_t            state_q, state_d;
  logic [7:0]        pend_q;
  logic [4:0]        dest_q, rd_dest;
  logic              err_q;
  logic [15:0]       len_q;
  logic [IW-1:0]     idle_q;
  logic              full, empty, space, close, push, push_last, load, drop, new_pkt;
  entry_t            wr_e, rd_e;
  logic [ENTRY_W+4:0] rd_w;
  assign space   = ~full | m_axis_tready;
  assign close   = (idle_q == IW'(IDLE_CYCLES - 1)) | (len_q == 16'(MAX_PKT_LEN));
  assign wr_e    = {push_last & err_q, push_last, pend_q};
  assign new_pkt = load & ((state_q == ST_IDLE) | push_last);
  assign {rd_dest, rd_e} = rd_w;
  uart_pkt_fifo #(.W(ENTRY_W + 5), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .wr(push), .wr_data({dest_q, wr_e}),
    .rd(m_axis_tready), .rd_data(rd_w), .full(full), .empty(empty)
  );
  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    push_last = 1'b0;
    load      = 1'b0;
    drop      = 1'b0;
    if (state_q == ST_IDLE) begin
      load    = rx_valid;
      state_d = rx_valid ? ST_HOLD : ST_IDLE;
    end else if (close) begin
      push      = space;
      push_last = space;
      load      = space & rx_valid;
      drop      = ~space & rx_valid;
      state_d   = (space & ~rx_valid) ? ST_IDLE : ST_HOLD;
    end else if (rx_valid) begin
      push = space;
      load = space;
      drop = ~space;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  // A closing push with a new byte in the same cycle hands the pending slot to the next packet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      dest_q <= '0;
      err_q  <= 1'b0;
      len_q  <= '0;
      idle_q <= '0;
    end else begin
      if (load) pend_q <= rx_data;
      if (new_pkt) begin
        dest_q <= tdest;
        len_q  <= 16'd1;
      end else if (load) len_q <= len_q + 16'd1;
      if (new_pkt) err_q <= rx_err;
      else if (load | drop) err_q <= err_q | rx_err | drop;
      if (load) idle_q <= '0;
      else if (idle_q != IW'(IDLE_CYCLES - 1)) idle_q <= idle_q + 1'b1;
    end
  end
  assign m_axis_tvalid = ~empty;
  assign m_axis_tdata  = m_axis_tvalid ? rd_e.data : 8'h00;
  assign m_axis_tlast  = m_axis_tvalid & rd_e.last;
  assign m_axis_tuser  = m_axis_tvalid & rd_e.err;
  assign m_axis_tdest  = m_axis_tvalid ? rd_dest : 5'd0;
  assign m_axis_tkeep  = 1'b1;
`ifdef UART_PKT_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (m_axis_tvalid & m_axis_tready & m_axis_tlast & (pkt_cnt != 16'hFFFF)) pkt_cnt <= pkt_cnt + 16'd1;
      if (drop & (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
    end
  end
`else
  assign pkt_cnt  = 16'd0;
  assign drop_cnt = 16'd0;
`endif
endmodule
